// File: rtl/op_handler_dispatcher.sv
// rtl/op_handler_dispatcher.sv - routes opcodes to downstream handlers through a programmable table
//
// Purpose: looks up op_cmd in a 2**CMD_WIDTH x 4-bit routing table, starts the
// selected handler with a one-cycle h_trigger pulse and reports its completion
// as a one-cycle done pulse. Entries that name a handler >= NUM_HANDLERS fall
// back to DEFAULT_HANDLER.
// Optional feature macro: OP_DISPATCH_TIMEOUT_EN (WAIT_DONE watchdog + sticky err).
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   op_cmd, trigger       - upstream opcode command and start pulse
//   rdy, done             - able to accept (IDLE only), completion pulse
//   map_wr_en/cmd/idx     - routing table write port
//   h_trigger             - per-handler start pulse (registered)
//   h_done, h_rdy         - per-handler completion and ready
//   busy_idx              - handler index of the op in flight
//   err                   - sticky watchdog timeout flag
module op_handler_dispatcher #(
  parameter int NUM_HANDLERS    = 3,
  parameter int CMD_WIDTH       = 4,
  parameter int DEFAULT_HANDLER = 2,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CMD_WIDTH-1:0]    op_cmd,
  input  logic                    trigger,
  output logic                    rdy,
  output logic                    done,
  input  logic                    map_wr_en,
  input  logic [CMD_WIDTH-1:0]    map_wr_cmd,
  input  logic [3:0]              map_wr_idx,
  output logic [NUM_HANDLERS-1:0] h_trigger,
  input  logic [NUM_HANDLERS-1:0] h_done,
  input  logic [NUM_HANDLERS-1:0] h_rdy,
  output logic [3:0]              busy_idx,
  output logic                    err
);

  localparam int         DEPTH   = 1 << CMD_WIDTH;
  localparam logic [3:0] DEF_IDX = 4'(DEFAULT_HANDLER);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISPATCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  generate
    if (NUM_HANDLERS < 2 || NUM_HANDLERS > 16 || DEFAULT_HANDLER < 0 ||
        DEFAULT_HANDLER >= NUM_HANDLERS || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("op_handler_dispatcher: illegal parameter combination");
    end
  endgenerate

  logic [1:0]              state_q, state_d;
  logic [3:0]              table_q [DEPTH];
  logic [3:0]              table_d [DEPTH];
  logic [3:0]              busy_idx_q, busy_idx_d;
  logic [NUM_HANDLERS-1:0] h_trigger_q, h_trigger_d;
  logic                    done_q, done_d;

  logic [3:0]  raw_idx;
  logic [3:0]  lookup_idx;
  logic [15:0] h_rdy_ext;
  logic [15:0] h_done_ext;
  logic [15:0] onehot;
  logic        accept;

`ifdef OP_DISPATCH_TIMEOUT_EN
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // Handler vectors are widened to 16 bits so a 4-bit index always selects in range.
  assign h_rdy_ext  = 16'(h_rdy);
  assign h_done_ext = 16'(h_done);

  // Lookup reads the registered table, so a same-cycle write only affects later ops.
  assign raw_idx    = table_q[op_cmd];
  assign lookup_idx = (int'(raw_idx) >= NUM_HANDLERS) ? DEF_IDX : raw_idx;
  assign onehot     = 16'(1) << lookup_idx;

  assign rdy    = (state_q == ST_IDLE) && h_rdy_ext[lookup_idx];
  assign accept = trigger && rdy;

  always_comb begin
    state_d     = state_q;
    busy_idx_d  = busy_idx_q;
    h_trigger_d = '0;
    done_d      = 1'b0;
    table_d     = table_q;
    if (map_wr_en) begin
      table_d[map_wr_cmd] = map_wr_idx;
    end
`ifdef OP_DISPATCH_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_DISPATCH;
          busy_idx_d  = lookup_idx;
          h_trigger_d = onehot[NUM_HANDLERS-1:0];
`ifdef OP_DISPATCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_DISPATCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Only the latched handler can complete the op; other h_done bits are ignored.
        if (h_done_ext[busy_idx_q]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef OP_DISPATCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_idx_q  <= DEF_IDX;
      h_trigger_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= DEF_IDX;
      end
`ifdef OP_DISPATCH_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_idx_q  <= busy_idx_d;
      h_trigger_q <= h_trigger_d;
      done_q      <= done_d;
      table_q     <= table_d;
`ifdef OP_DISPATCH_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  assign h_trigger = h_trigger_q;
  assign done      = done_q;
  assign busy_idx  = busy_idx_q;
`ifdef OP_DISPATCH_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_op_handler_dispatcher.sv
// tb/tb_op_handler_dispatcher.sv - directed self-checking bench for op_handler_dispatcher
module tb_op_handler_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op_cmd;
  logic       trigger;
  logic       rdy;
  logic       done;
  logic       map_wr_en;
  logic [3:0] map_wr_cmd;
  logic [3:0] map_wr_idx;
  logic [2:0] h_trigger;
  logic [2:0] h_done;
  logic [2:0] h_rdy;
  logic [3:0] busy_idx;
  logic       err;

  int errors = 0;
  int checks = 0;
  int done_seen;

  op_handler_dispatcher #(
    .NUM_HANDLERS   (3),
    .CMD_WIDTH      (4),
    .DEFAULT_HANDLER(2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_cmd    (op_cmd),
    .trigger   (trigger),
    .rdy       (rdy),
    .done      (done),
    .map_wr_en (map_wr_en),
    .map_wr_cmd(map_wr_cmd),
    .map_wr_idx(map_wr_idx),
    .h_trigger (h_trigger),
    .h_done    (h_done),
    .h_rdy     (h_rdy),
    .busy_idx  (busy_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic map_write(input logic [3:0] cmd, input logic [3:0] idx);
    map_wr_en  = 1'b1;
    map_wr_cmd = cmd;
    map_wr_idx = idx;
    step();
    map_wr_en  = 1'b0;
  endtask

  // Full op from IDLE: trigger, expect one-cycle h_trigger, complete via that handler.
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [2:0] exp_trig);
    op_cmd  = cmd;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check({tag, "_htrig"}, 16'(h_trigger), 16'(exp_trig));
    step();
    check({tag, "_htrig_off"}, 16'(h_trigger), 16'h0);
    h_done = exp_trig;
    step();
    h_done = 3'b000;
    check({tag, "_done"}, 16'(done), 16'h1);
    step();
    check({tag, "_done_off"}, 16'(done), 16'h0);
  endtask

  initial begin
    reset      = 1'b1;
    op_cmd     = 4'd0;
    trigger    = 1'b0;
    map_wr_en  = 1'b0;
    map_wr_cmd = 4'd0;
    map_wr_idx = 4'd0;
    h_done     = 3'b000;
    h_rdy      = 3'b111;
    step();
    step();
    check("rst_htrig", 16'(h_trigger), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_busy", 16'(busy_idx), 16'h2);
    check("rst_err", 16'(err), 16'h0);
    check("rst_rdy", 16'(rdy), 16'h1);
    reset = 1'b0;
    step();

    // Basic routing: cmd 3 -> handler 1.
    map_write(4'd1, 4'd0);
    map_write(4'd3, 4'd1);
    op_cmd = 4'd3;
    h_rdy  = 3'b101;
    #1;
    check("rdy_follows_hrdy_lo", 16'(rdy), 16'h0);
    h_rdy = 3'b111;
    #1;
    check("rdy_follows_hrdy_hi", 16'(rdy), 16'h1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("op3_htrig", 16'(h_trigger), 16'h2);
    check("op3_busy", 16'(busy_idx), 16'h1);
    check("op3_rdy_busy", 16'(rdy), 16'h0);
    step();
    check("op3_htrig_once", 16'(h_trigger), 16'h0);
    step();
    check("op3_no_early_done", 16'(done), 16'h0);
    h_done = 3'b010;
    step();
    h_done = 3'b000;
    check("op3_done", 16'(done), 16'h1);
    check("op3_rdy_after", 16'(rdy), 16'h1);
    step();
    check("op3_done_once", 16'(done), 16'h0);

    // Unmapped and out-of-range entries go to the default handler.
    run_op("unmapped5", 4'd5, 3'b100);
    map_write(4'd5, 4'd7);
    run_op("oor5", 4'd5, 3'b100);

    // h_done while IDLE is ignored.
    h_done = 3'b111;
    step();
    h_done = 3'b000;
    check("idle_hdone_ignored", 16'(done), 16'h0);

    // No re-route in flight; wrong h_done and extra trigger are dropped.
    op_cmd  = 4'd1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("inflight_htrig", 16'(h_trigger), 16'h1);
    step();
    op_cmd  = 4'd3;
    h_done  = 3'b010;
    trigger = 1'b1;
    step();
    h_done  = 3'b000;
    trigger = 1'b0;
    check("inflight_wrong_done", 16'(done), 16'h0);
    check("inflight_no_trig", 16'(h_trigger), 16'h0);
    step();
    check("inflight_no_trig2", 16'(h_trigger), 16'h0);
    check("inflight_busy", 16'(busy_idx), 16'h0);
    h_done = 3'b001;
    step();
    h_done = 3'b000;
    check("inflight_done", 16'(done), 16'h1);
    step();

    // Same-cycle write and accept: old entry routes this op, new entry the next.
    op_cmd     = 4'd1;
    trigger    = 1'b1;
    map_wr_en  = 1'b1;
    map_wr_cmd = 4'd1;
    map_wr_idx = 4'd1;
    step();
    trigger   = 1'b0;
    map_wr_en = 1'b0;
    check("samecyc_old_route", 16'(h_trigger), 16'h1);
    step();
    h_done = 3'b001;
    step();
    h_done = 3'b000;
    check("samecyc_done", 16'(done), 16'h1);
    step();
    run_op("samecyc_new", 4'd1, 3'b010);

    // Trigger with rdy=0 is dropped.
    h_rdy   = 3'b000;
    op_cmd  = 4'd1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    h_rdy   = 3'b111;
    check("notrdy_dropped", 16'(h_trigger), 16'h0);
    step();
    check("notrdy_dropped2", 16'(h_trigger), 16'h0);

    // Watchdog behaviour.
    op_cmd  = 4'd1;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("wd_htrig", 16'(h_trigger), 16'h2);
    done_seen = 0;
`ifdef OP_DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    check("wd_no_early_done", 16'(done_seen), 16'h0);
    check("wd_err_before", 16'(err), 16'h0);
    step();
    check("wd_done", 16'(done), 16'h1);
    check("wd_err", 16'(err), 16'h1);
    step();
    check("wd_err_sticky", 16'(err), 16'h1);
    op_cmd  = 4'd3;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
`else
    for (int i = 0; i < 100; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    check("nowd_no_done", 16'(done_seen), 16'h0);
    check("nowd_err", 16'(err), 16'h0);
`endif

    // Reset mid-WAIT_DONE: outputs go to reset values without a clock edge.
    check("prerst_busy", 16'(busy_idx), 16'h1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_busy", 16'(busy_idx), 16'h2);
    check("arst_err", 16'(err), 16'h0);
    check("arst_done", 16'(done), 16'h0);
    check("arst_htrig", 16'(h_trigger), 16'h0);
    step();
    reset  = 1'b0;
    h_done = 3'b010;
    step();
    h_done = 3'b000;
    check("postrst_no_done", 16'(done), 16'h0);
    step();
    check("postrst_no_done2", 16'(done), 16'h0);
    run_op("postrst_tbl1", 4'd1, 3'b100);
    run_op("postrst_tbl3", 4'd3, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
